// File: rtl/sdram_arb.sv
// sdram_arb: arbitrates the fetch and data ports onto the single SDRAM controller request interface.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
//
// state   | meaning
// IDLE    | no transaction; sample i_req/d_req and grant one
// ISSUE   | request presented; waiting for the controller to accept (m_busy low)
// WAIT_RD | read accepted; waiting for m_read_ready
// WAIT_WR | write accepted; waiting for the controller to go idle
// ACK     | ack pulse cycle; requests ignored so the client can drop its req
module sdram_arb #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read_req,
  output logic              m_write_req,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_busy,
  input  logic              m_read_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, ACK} state_t;

  state_t state;
  logic   grant_d;
  logic   pick_d;

`ifdef SDRAM_ARB_RR_EN
  logic last_d;

  // On contention the port that did not win last time goes first.
  always_comb begin
    pick_d = 1'b0;
    if (d_req && (!i_req || !last_d))
      pick_d = 1'b1;
  end
`else
  always_comb begin
    pick_d = 1'b0;
    if (d_req)
      pick_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      m_read_req  <= 1'b0;
      m_write_req <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_data      <= '0;
      d_rdata     <= '0;
      grant_d     <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            grant_d <= pick_d;
`ifdef SDRAM_ARB_RR_EN
            last_d  <= pick_d;
`endif
            if (pick_d) begin
              m_addr <= d_addr;
              if (d_we) begin
                m_wdata     <= d_wdata;
                m_write_req <= 1'b1;
              end else begin
                m_read_req  <= 1'b1;
              end
            end else begin
              m_addr     <= i_addr;
              m_read_req <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The controller latches the request on the same edge it sees itself idle.
          if (!m_busy) begin
            m_read_req  <= 1'b0;
            m_write_req <= 1'b0;
            state       <= m_write_req ? WAIT_WR : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (m_read_ready) begin
            if (grant_d) begin
              d_rdata <= m_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_data  <= m_rdata;
              i_ack   <= 1'b1;
            end
            state <= ACK;
          end
        end
        WAIT_WR: begin
          if (!m_busy) begin
            d_ack <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: a cycle-counting SDRAM controller stand-in,
// a transaction-level reference memory and a per-cycle compare process.
module tb_sdram_arb;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, i_data, d_rdata, m_wdata, m_rdata;
  logic          i_ack, d_ack, m_read_req, m_write_req, m_busy, m_read_ready;

  always #5 clk = ~clk;

  sdram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_rdata(m_rdata), .m_busy(m_busy), .m_read_ready(m_read_ready)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk_eq(input string name, input longint unsigned act, input longint unsigned exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h3C3C;
  endfunction

  // Controller stand-in: read ready 5 edges after acceptance, write busy for 3 edges.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            ctl_cnt = 0;
  logic          ctl_rd = 1'b0;
  logic [DW-1:0] ctl_data = '0;
  logic          ext_busy = 1'b0;

  assign m_busy       = ext_busy || (ctl_cnt != 0);
  assign m_read_ready = ctl_rd && (ctl_cnt == 5);
  assign m_rdata      = ctl_data;

  initial forever begin
    @(posedge clk);
    if (ctl_cnt != 0) begin
      if ((ctl_rd && ctl_cnt == 5) || (!ctl_rd && ctl_cnt == 3)) ctl_cnt <= 0;
      else ctl_cnt <= ctl_cnt + 1;
    end else if (!ext_busy && (m_read_req || m_write_req)) begin
      ctl_cnt <= 1;
      ctl_rd  <= m_read_req;
      if (m_write_req) mem[m_addr] = m_wdata;
      else ctl_data <= mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
    end
  end

  // Reference memory as the clients see it.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  bit            i_pending = 0, d_pending = 0;
  logic [DW-1:0] i_exp = '0, d_exp = '0;
  int            cyc = 0, grant_cyc = 0, ack_cyc = 0;
  int            req_rises = 0, rd_req_cyc = 0, wr_req_cyc = 0, i_acks = 0, d_acks = 0;
  bit            in_txn = 0, txn_wr = 0;
  logic [AW-1:0] txn_addr = '0;
  logic [DW-1:0] txn_wdata = '0;
  bit            order[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      in_txn = 0;
    end else begin
      rd_req_cyc += int'(m_read_req);
      wr_req_cyc += int'(m_write_req);
      if (m_read_req || m_write_req) begin
        chk_eq("single_req", m_read_req && m_write_req, 0);
        if (!in_txn) begin
          in_txn = 1; txn_addr = m_addr; txn_wdata = m_wdata; txn_wr = m_write_req;
          grant_cyc = cyc; req_rises++;
          if (m_write_req)
            chk_eq("grant_wr_src", d_pending && d_we && m_addr == d_addr && m_wdata == d_wdata, 1);
          else
            chk_eq("grant_rd_src", (i_pending && m_addr == i_addr) ||
                                   (d_pending && !d_we && m_addr == d_addr), 1);
        end
      end
      if (in_txn) begin
        chk_eq("m_addr_stable", m_addr, txn_addr);
        if (txn_wr) chk_eq("m_wdata_stable", m_wdata, txn_wdata);
      end
      if (i_ack || d_ack) chk_eq("dual_ack", i_ack && d_ack, 0);
      if (i_ack) begin
        chk_eq("i_ack_pending", i_pending, 1);
        chk_eq("i_ack_txn_read", in_txn && !txn_wr, 1);
        chk_eq("i_data", i_data, i_exp);
        i_pending = 0; i_acks++; order.push_back(1'b0); ack_cyc = cyc; in_txn = 0;
      end
      if (d_ack) begin
        chk_eq("d_ack_pending", d_pending, 1);
        chk_eq("d_ack_txn_kind", in_txn && (txn_wr == d_we), 1);
        if (!d_we) chk_eq("d_rdata", d_rdata, d_exp);
        d_pending = 0; d_acks++; order.push_back(1'b1); ack_cyc = cyc; in_txn = 0;
      end
    end
  end

  task automatic clear_counts();
    req_rises = 0; rd_req_cyc = 0; wr_req_cyc = 0; i_acks = 0; d_acks = 0;
  endtask

  // Called at posedge+2; returns at posedge+2 one cycle after the ack, req already low.
  task automatic do_i(input logic [AW-1:0] a, input bit hold);
    bit got;
    got = 0;
    i_addr = a; i_exp = ref_rd(a); i_pending = 1; i_req = 1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #2;
      if (i_ack) got = 1;
    end
    chk_eq("i_ack_timeout", got, 1);
    if (!hold) i_req = 0;
    @(posedge clk); #2;
    i_req = 0;
  endtask

  task automatic do_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit hold);
    bit got;
    got = 0;
    d_we = we; d_addr = a; d_wdata = wd;
    if (we) ref_mem[a] = wd;
    else d_exp = ref_rd(a);
    d_pending = 1; d_req = 1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #2;
      if (d_ack) got = 1;
    end
    chk_eq("d_ack_timeout", got, 1);
    if (!hold) d_req = 0;
    @(posedge clk); #2;
    d_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_order[8];
    bit got;
    int di, ii;
    bit last_d;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    mem[24'h000123] = 16'hBEEF;
    ref_mem[24'h000123] = 16'hBEEF;

    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_i_ack", i_ack, 0);
    chk_eq("rst_d_ack", d_ack, 0);
    chk_eq("rst_m_read_req", m_read_req, 0);
    chk_eq("rst_m_write_req", m_write_req, 0);
    chk_eq("rst_m_addr", m_addr, 0);
    chk_eq("rst_m_wdata", m_wdata, 0);
    chk_eq("rst_i_data", i_data, 0);
    chk_eq("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #2;

    // Fetch read with the controller idle.
    clear_counts();
    do_i(24'h000123, 0);
    chk_eq("fetch_data", i_data, 16'hBEEF);
    chk_eq("fetch_req_cycles", rd_req_cyc, 1);
    chk_eq("fetch_latency", ack_cyc - grant_cyc, 6);
    chk_eq("fetch_acks", i_acks, 1);

    // Data write, then read back.
    clear_counts();
    do_d(1, 24'h400010, 16'h5A5A, 0);
    chk_eq("write_latency", ack_cyc - grant_cyc, 5);
    chk_eq("write_req_cycles", wr_req_cyc, 1);
    chk_eq("write_acks", d_acks, 1);
    chk_eq("write_m_addr", m_addr, 24'h400010);
    chk_eq("write_m_wdata", m_wdata, 16'h5A5A);
    clear_counts();
    do_d(0, 24'h400010, 16'h0000, 0);
    chk_eq("readback_data", d_rdata, 16'h5A5A);
    chk_eq("readback_latency", ack_cyc - grant_cyc, 6);

    // Controller busy for 8 cycles while the request is presented.
    clear_counts();
    ext_busy = 1;
    fork
      begin
        repeat (8) @(posedge clk);
        #2 ext_busy = 0;
      end
    join_none
    do_i(24'h000456, 0);
    chk_eq("busy_req_cycles", rd_req_cyc, 8);
    chk_eq("busy_acks", i_acks, 1);
    chk_eq("busy_req_rises", req_rises, 1);

    // Client keeps req high one cycle past its ack.
    clear_counts();
    do_d(0, 24'h000321, 16'h0000, 1);
    repeat (6) @(posedge clk);
    #2;
    chk_eq("hold_req_rises", req_rises, 1);
    chk_eq("hold_acks", d_acks, 1);

    // Both ports requesting continuously, four transactions each.
    clear_counts();
    order.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) do_d(0, AW'(24'h000200 + k), 16'h0000, 0);
      end
      begin
        for (int k = 0; k < 4; k++) do_i(AW'(24'h000100 + k), 0);
      end
    join
    di = 4; ii = 4; last_d = 0;
    for (int k = 0; k < 8; k++) begin
      if (di > 0 && ii > 0) begin
`ifdef SDRAM_ARB_RR_EN
        exp_order[k] = !last_d;
`else
        exp_order[k] = 1'b1;
`endif
      end else begin
        exp_order[k] = (di > 0);
      end
      last_d = exp_order[k];
      if (exp_order[k]) di--; else ii--;
    end
    chk_eq("order_len", order.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < order.size()) chk_eq($sformatf("order_%0d_is_data", k), order[k], exp_order[k]);

    // Reset while the read is outstanding; the late m_read_ready must be ignored.
    clear_counts();
    i_addr = 24'h000777; i_exp = ref_rd(24'h000777); i_pending = 1; i_req = 1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk); #2;
      if (m_read_req) got = 1;
    end
    chk_eq("abort_req_seen", got, 1);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk); #2;
      if (!m_read_req) got = 1;
    end
    chk_eq("abort_accepted", got, 1);
    rst = 1; i_req = 0; i_pending = 0;
    @(posedge clk); #2;
    rst = 0;
    repeat (10) @(posedge clk);
    #2;
    chk_eq("abort_acks", i_acks, 0);
    chk_eq("abort_i_data", i_data, 0);
    chk_eq("abort_m_addr", m_addr, 0);
    chk_eq("abort_m_read_req", m_read_req, 0);
    chk_eq("abort_req_rises", req_rises, 1);
    clear_counts();
    do_i(24'h000777, 0);
    chk_eq("post_abort_acks", i_acks, 1);
    chk_eq("post_abort_data", i_data, 16'h3B4B);
    chk_eq("post_abort_latency", ack_cyc - grant_cyc, 6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
